// File: rtl/fsm_seek_ctrl.sv
// ---------------------------------------------------------------------------
// fsm_seek_ctrl
//   Run controller for a serial bit-pattern seek. A start pulse latches the
//   pattern, length, target count and window, then the controller watches the
//   qualified bit stream for the pattern, with overlapping matches allowed.
//   A run ends with a done pulse when the target count is reached, with a
//   timeout pulse when the accepted-bit window runs out first, or silently on
//   abort.
//
// Ports
//   clk          in   clock, rising edge
//   aresetn      in   asynchronous active-low reset
//   cfg_pattern  in   pattern; bit [cfg_len-1] earliest in time, bit 0 latest
//   cfg_len      in   pattern length, valid 1..MAX_LEN
//   cfg_target   in   match count ending the run (0 = unlimited)
//   cfg_window   in   accepted bits per run (0 = unlimited)
//   start        in   arms a run when idle
//   abort        in   cancels a run (wins over start)
//   bit_valid    in   qualifies bit_in
//   bit_in       in   serial data bit
//   busy         out  run active
//   match        out  one-cycle pulse per detected occurrence
//   match_count  out  matches in current or last run (saturating)
//   done         out  one-cycle pulse, target reached
//   timeout      out  one-cycle pulse, window expired
//   err          out  one-cycle pulse, start rejected for bad cfg_len
// ---------------------------------------------------------------------------
module fsm_seek_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               done,
  output logic               timeout,
  output logic               err
);

  typedef enum logic [0:0] {IDLE, SEEK} state_t;

  state_t             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   target_q;
  logic [WIN_W-1:0]   window_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [CNT_W-1:0]   count_q;
  logic               busy_q;
  logic               match_q;
  logic               done_q;
  logic               timeout_q;
  logic               err_q;

  // Next values for the current bit, valid whenever a bit is accepted.
  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W:0]     fill_inc;
  logic               fill_full;
  logic [LEN_W-1:0]   fill_d;
  logic [WIN_W-1:0]   win_cnt_d;
  logic [CNT_W-1:0]   count_d;
  logic [MAX_LEN-1:0] len_mask;
  logic               pat_eq;
  logic               is_match;
  logic               target_hit;
  logic               window_hit;
  logic               cfg_len_ok;

  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // Newest bit enters at the LSB, so history[len-1:0] lines up with the
  // pattern's earliest-at-MSB ordering.
  assign hist_d = {hist_q[MAX_LEN-2:0], bit_in};

  // Fill count saturates at the latched length; "full" means this bit
  // completes at least len bits of history.
  assign fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
  assign fill_full = (fill_inc >= {1'b0, len_q});
  assign fill_d    = fill_full ? len_q : fill_inc[LEN_W-1:0];

  // Only the low len_q history bits take part in the comparison.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end
  endgenerate

  assign pat_eq    = (((hist_d ^ pat_q) & len_mask) == '0);
  assign is_match  = fill_full && pat_eq;

  assign count_d   = (&count_q) ? count_q : count_q + CNT_W'(1);
  assign win_cnt_d = win_cnt_q + WIN_W'(1);

  assign target_hit = is_match && (target_q != '0) && (count_d == target_q);
  assign window_hit = (window_q != '0) && (win_cnt_d == window_q);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      target_q  <= '0;
      window_q  <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      win_cnt_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      match_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (cfg_len_ok) begin
              pat_q     <= cfg_pattern;
              len_q     <= cfg_len;
              target_q  <= cfg_target;
              window_q  <= cfg_window;
              hist_q    <= '0;
              fill_q    <= '0;
              win_cnt_q <= '0;
              count_q   <= '0;
              busy_q    <= 1'b1;
              state_q   <= SEEK;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SEEK: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bit_valid) begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            win_cnt_q <= win_cnt_d;
            if (is_match) begin
              match_q <= 1'b1;
              count_q <= count_d;
            end
            // Target takes priority when both limits land on the same bit.
            if (target_hit) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (window_hit) begin
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign match       = match_q;
  assign match_count = count_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fsm_seek_ctrl.sv
module tb_fsm_seek_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int WIN_W   = 16;

  logic               clk;
  logic               aresetn;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic [WIN_W-1:0]   cfg_window;
  logic               start;
  logic               abort;
  logic               bit_valid;
  logic               bit_in;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               done;
  logic               timeout;
  logic               err;

  int n_tests;
  int n_fail;

  fsm_seek_ctrl #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W),
    .WIN_W  (WIN_W)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_target (cfg_target),
    .cfg_window (cfg_window),
    .start      (start),
    .abort      (abort),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .busy       (busy),
    .match      (match),
    .match_count(match_count),
    .done       (done),
    .timeout    (timeout),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full output vector after the most recent edge.
  task automatic check_out(input string tag, input logic b, input logic m,
                           input int cnt, input logic d, input logic t, input logic e);
    check_eq({tag, ".busy"},    32'(busy),        32'(b));
    check_eq({tag, ".match"},   32'(match),       32'(m));
    check_eq({tag, ".count"},   32'(match_count), 32'(cnt));
    check_eq({tag, ".done"},    32'(done),        32'(d));
    check_eq({tag, ".timeout"}, 32'(timeout),     32'(t));
    check_eq({tag, ".err"},     32'(err),         32'(e));
  endtask

  task automatic do_start(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic [CNT_W-1:0] tgt, input logic [WIN_W-1:0] win);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_target  = tgt;
    cfg_window  = win;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    // Scramble cfg afterwards: the run must use the latched copy.
    cfg_pattern = ~pat;
    cfg_len     = 4'd1;
    cfg_target  = 8'd0;
    cfg_window  = 16'd1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    aresetn     = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_target  = '0;
    cfg_window  = '0;
    start       = 1'b0;
    abort       = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;

    tick();
    tick();
    check_out("reset", 0, 0, 0, 0, 0, 0);
    aresetn = 1'b1;
    tick();

    // T1: 101, len 3, target 2, no window; overlapping matches on 10101.
    do_start(8'b101, 4'd3, 8'd2, 16'd0);
    check_out("t1.start", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1); check_out("t1.b1", 1, 0, 0, 0, 0, 0);
    send_bit(1'b0); check_out("t1.b2", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1); check_out("t1.b3", 1, 1, 1, 0, 0, 0);
    send_bit(1'b0); check_out("t1.b4", 1, 0, 1, 0, 0, 0);
    send_bit(1'b1); check_out("t1.b5", 0, 1, 2, 1, 0, 0);
    tick();         check_out("t1.after", 0, 0, 2, 0, 0, 0);

    // T2: 111, len 3, target 1, window 4; stream 1101 times out.
    do_start(8'b111, 4'd3, 8'd1, 16'd4);
    check_out("t2.start", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1); check_out("t2.b1", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1); check_out("t2.b2", 1, 0, 0, 0, 0, 0);
    send_bit(1'b0); check_out("t2.b3", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1); check_out("t2.b4", 0, 0, 0, 0, 1, 0);
    tick();         check_out("t2.after", 0, 0, 0, 0, 0, 0);

    // T3: 11, len 2, target 3, window 4; bit 4 hits both limits -> done only.
    do_start(8'b11, 4'd2, 8'd3, 16'd4);
    send_bit(1'b1); check_out("t3.b1", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1); check_out("t3.b2", 1, 1, 1, 0, 0, 0);
    send_bit(1'b1); check_out("t3.b3", 1, 1, 2, 0, 0, 0);
    send_bit(1'b1); check_out("t3.b4", 0, 1, 3, 1, 0, 0);
    tick();         check_out("t3.after", 0, 0, 3, 0, 0, 0);

    // T4: gaps of bit_valid low do not shift history or count window.
    // Window 6: if idle cycles counted, the run would have timed out.
    do_start(8'b101, 4'd3, 8'd0, 16'd6);
    send_bit(1'b1); idle_cycles(3); check_out("t4.gap1", 1, 0, 0, 0, 0, 0);
    send_bit(1'b0); idle_cycles(3); check_out("t4.gap2", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1); check_out("t4.b3", 1, 1, 1, 0, 0, 0);
    idle_cycles(3); check_out("t4.gap3", 1, 0, 1, 0, 0, 0);
    send_bit(1'b0); check_out("t4.b4", 1, 0, 1, 0, 0, 0);
    // Abort with a bit that would otherwise complete 101: no match counted.
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check_out("t4.abort", 0, 0, 1, 0, 0, 0);

    // T5: rejected starts.
    cfg_pattern = 8'b101; cfg_len = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    check_out("t5.len0", 0, 0, 1, 0, 0, 1);
    tick(); check_out("t5.len0.after", 0, 0, 1, 0, 0, 0);
    cfg_len = 4'd9; start = 1'b1;
    tick(); start = 1'b0;
    check_out("t5.len9", 0, 0, 1, 0, 0, 1);
    cfg_len = 4'd3; start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    check_out("t5.startabort", 0, 0, 1, 0, 0, 0);
    tick(); check_out("t5.still_idle", 0, 0, 1, 0, 0, 0);

    // T6: abort mid-run, then reset mid-run, then a clean run.
    do_start(8'b101, 4'd3, 8'd1, 16'd0);
    check_out("t6.start", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    check_out("t6.abort", 0, 0, 0, 0, 0, 0);
    do_start(8'b101, 4'd3, 8'd1, 16'd0);
    send_bit(1'b1);
    send_bit(1'b0);
    // Drop reset asynchronously, mid-cycle.
    #2 aresetn = 1'b0;
    #1 check_out("t6.async_rst", 0, 0, 0, 0, 0, 0);
    tick();
    aresetn = 1'b1;
    tick();
    do_start(8'b101, 4'd3, 8'd1, 16'd0);
    send_bit(1'b0); check_out("t6.r1", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1); check_out("t6.r2", 1, 0, 0, 0, 0, 0);
    send_bit(1'b0); check_out("t6.r3", 1, 0, 0, 0, 0, 0);
    send_bit(1'b1); check_out("t6.r4", 0, 1, 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
